// File: rtl/uart_rx_engine_pkg.sv
// Shared UART constants, FSM state encoding and the 3-sample majority vote.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_rx_engine_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] MID_LO   = 4'd7;
  localparam logic [CNT_W-1:0] MID_C    = 4'd8;
  localparam logic [CNT_W-1:0] MID_HI   = 4'd9;
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Holding-register handshake and status between the RX engine (master) and its register block (slave).
interface uart_rx_engine_if;

  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       flag_clr_i;
  logic       busy_o;

  modport master (
    output rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
    input  rx_ready_i, flag_clr_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
    output rx_ready_i, flag_clr_i
  );

endinterface

// File: rtl/uart_rx_engine_baud_nco.sv
// Phase-accumulator baud generator: one-clk tick on each accumulator carry-out.
module uart_baud_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCO_W-1:0] inc_i,
  output logic             tick_o
);

  logic [NCO_W-1:0] acc_q, acc_d;

  always_comb begin
    {tick_o, acc_d} = {1'b0, acc_q} + {1'b0, inc_i};
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// 16x-oversampled 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for an 8-bit + parity + stop frame and the parity_odd_i port.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             uart_rx,
  input  logic             rx_en_i,
  input  logic [NCO_W-1:0] baud_inc_i,
`ifdef UART_RX_PARITY_EN
  input  logic             parity_odd_i,
`endif
  uart_rx_engine_if.master rx_if
);

  logic tick;

  uart_baud_nco #(.NCO_W(NCO_W)) u_nco (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (baud_inc_i),
    .tick_o (tick)
  );

  logic             rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [1:0]       init_q, init_d;
  logic             armed_q, armed_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       smp_q, smp_d;
  logic             bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             perr_q, perr_d;
`endif
  logic             mid_vote;
  logic             commit;
  logic             ovr_set;

  // The line is only trusted once the synchroniser holds post-reset samples and has been seen
  // idle high, so a reset released mid-character cannot start a frame on a stale low level.
  always_comb begin
    rx_meta_d = uart_rx;
    rx_s_d    = rx_meta_q;
    init_d    = {init_q[0], 1'b1};
    armed_d   = armed_q | (init_q[1] & rx_s_q);
  end

  assign mid_vote = maj3(smp_q[0], smp_q[1], rx_s_q);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    if (tick) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == MID_LO) smp_d[0] = rx_s_q;
      if (cnt_q == MID_C)  smp_d[1] = rx_s_q;
      if (cnt_q == MID_HI) bit_d    = mid_vote;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_en_i && armed_q && !rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (tick && cnt_q == CNT_LAST) begin
          if (bit_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick && cnt_q == MID_HI) shift_d = {mid_vote, shift_q[7:1]};
        if (tick && cnt_q == CNT_LAST) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick && cnt_q == CNT_LAST) begin
          par_err_d = ((^shift_q) ^ bit_q) != parity_odd_i;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop keeps the following start edge in view.
        if (tick && cnt_q == MID_HI) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en_i) begin
      state_d = ST_IDLE;
      commit  = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif

    if (commit) begin
      if (!valid_q || rx_if.rx_ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = ~mid_vote;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_err_q;
`endif
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && rx_if.rx_ready_i) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    ovr_d = (ovr_q & ~rx_if.flag_clr_i) | ovr_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      init_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      smp_q     <= '0;
      bit_q     <= 1'b0;
      // NOTE: datapath registers are reset too, because the byte is visible on outputs that must read 0.
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      init_q    <= init_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      smp_q     <= smp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_if.rx_data_o   = data_q;
  assign rx_if.rx_valid_o  = valid_q;
  assign rx_if.frame_err_o = ferr_q;
  assign rx_if.overrun_o   = ovr_q;
  assign rx_if.busy_o      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err_o = perr_q;
`else
  assign rx_if.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed and randomized frames against a behavioural holding-register model.
// Honours UART_RX_PARITY_EN for the frame format and the parity_odd_i port.
module tb_uart_rx_engine;

  localparam int CLK_PER_BIT = 64;
  localparam int IDLE_GAP    = 100;

  logic        clk     = 1'b0;
  logic        rst_ni  = 1'b1;
  logic        uart_rx = 1'b1;
  logic        rx_en   = 1'b0;
  logic [31:0] baud_inc = 32'h4000_0000;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd = 1'b0;
`endif

  uart_rx_engine_if rx_if ();

  uart_rx_engine #(.NCO_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .uart_rx    (uart_rx),
    .rx_en_i    (rx_en),
    .baud_inc_i (baud_inc),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i (parity_odd),
`endif
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned busy_fall_cyc = 0;
  int unsigned commit_delay = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_prev <= rx_if.busy_o;
    if (busy_prev && !rx_if.busy_o) busy_fall_cyc <= cyc;
  end

  // Reference model of the holding register
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_perr, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] d, input logic stop_bit, input logic pbit,
                              input logic ready_now);
    if (!m_valid || ready_now) begin
      m_data  = d;
      m_valid = 1'b1;
      m_ferr  = (stop_bit == 1'b0);
`ifdef UART_RX_PARITY_EN
      m_perr  = ((^d) ^ pbit) != parity_odd;
`else
      m_perr  = 1'b0;
`endif
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 32'(rx_if.rx_valid_o), 32'(m_valid));
    check({tag, "_data"},  32'(rx_if.rx_data_o),  32'(m_data));
    check({tag, "_ferr"},  32'(rx_if.frame_err_o), 32'(m_ferr));
    check({tag, "_perr"},  32'(rx_if.parity_err_o), 32'(m_perr));
    check({tag, "_ovr"},   32'(rx_if.overrun_o),  32'(m_ovr));
    check({tag, "_busy"},  32'(rx_if.busy_o),     32'(0));
  endtask

  task automatic consume();
    rx_if.rx_ready_i = 1'b1;
    @(negedge clk);
    rx_if.rx_ready_i = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    end
  endtask

  task automatic flag_clear();
    rx_if.flag_clr_i = 1'b1;
    @(negedge clk);
    rx_if.flag_clr_i = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drives one frame LSB first. ready_off != 0 pulses ready on the clk start+ready_off-1;
  // rst_bit >= 0 asserts reset halfway through that frame bit and returns immediately.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input int unsigned ready_off, input int rst_bit, output logic pbit);
    logic [10:0] bits;
    int nb;
    int unsigned ra;
    @(negedge clk);
    while (((cyc - rel_cyc) % 4) != 0) @(negedge clk);
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    pbit = (^d) ^ parity_odd ^ par_flip;
    bits[9] = pbit;
    bits[10] = stop_bit;
    nb = 11;
`else
    pbit = par_flip;
    bits[9] = stop_bit;
    nb = 10;
`endif
    last_start_cyc = cyc;
    ra = (ready_off != 0) ? last_start_cyc + ready_off - 1 : 0;
    for (int b = 0; b < nb; b++) begin
      uart_rx = bits[b];
      for (int k = 0; k < CLK_PER_BIT; k++) begin
        if (b == rst_bit && k == CLK_PER_BIT / 2) begin
          rst_ni = 1'b0;
          return;
        end
        if (ra != 0 && cyc == ra) rx_if.rx_ready_i = 1'b1;
        else if (ra != 0 && cyc == ra + 1) rx_if.rx_ready_i = 1'b0;
        @(negedge clk);
      end
    end
    uart_rx = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                      input int unsigned ready_off);
    logic pbit;
    send_frame(d, stop_bit, par_flip, ready_off, -1, pbit);
    model_commit(d, stop_bit, pbit, ready_off != 0);
  endtask

  initial begin
    logic pbit;
    logic [7:0] rd;
    logic rs, rf;
    rx_if.rx_ready_i = 1'b0;
    rx_if.flag_clr_i = 1'b0;
    model_reset();

    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_ni = 1'b1;
    rel_cyc = cyc;
    rx_en = 1'b1;
    repeat (10) @(negedge clk);

    // 1: basic byte, ready low, then handshake
    xfer(8'h9A, 1'b1, 1'b0, 0);
    check_all("t1_9a");
    commit_delay = busy_fall_cyc - last_start_cyc;
    check("t1_commit_latency_in_window",
          32'((commit_delay > 9 * CLK_PER_BIT) && (commit_delay < 10 * CLK_PER_BIT + 64)), 32'(1));
    consume();
    check("t1_valid_clears", 32'(rx_if.rx_valid_o), 32'(0));

    // 2: 20-clk low glitch is a false start
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    check("t2_busy_during_glitch", 32'(rx_if.busy_o), 32'(1));
    uart_rx = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
    check_all("t2_false_start");

    // 3: bad stop bit still delivers the byte with frame_err
    xfer(8'h55, 1'b0, 1'b0, 0);
    check_all("t3_ferr");
    consume();
    check("t3_ferr_cleared_by_handshake", 32'(rx_if.frame_err_o), 32'(0));
    xfer(8'h3C, 1'b1, 1'b0, 0);
    check_all("t3_good");
    consume();

    // 4: overrun keeps the first byte
    xfer(8'h11, 1'b1, 1'b0, 0);
    xfer(8'h22, 1'b1, 1'b0, 0);
    check_all("t4_overrun");
    flag_clear();
    check_all("t4_flag_clr");

    // 5: ready on exactly the commit clk replaces the byte without overrun
    consume();
    xfer(8'h11, 1'b1, 1'b0, 0);
    xfer(8'h22, 1'b1, 1'b0, commit_delay);
    check_all("t5_ready_at_commit");
    consume();

    // Receiver disabled: a low line is ignored
    rx_en = 1'b0;
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("rx_en_low_ignores_line", 32'(rx_if.busy_o), 32'(0));
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    rx_en = 1'b1;

    // 6: reset mid-DATA on a low data bit; stale low line must not start a frame
    xfer(8'h77, 1'b1, 1'b0, 0);
    send_frame(8'h9A, 1'b1, 1'b0, 0, 3, pbit);
    repeat (2) @(negedge clk);
    model_reset();
    check_all("t6_in_reset");
    rst_ni = 1'b1;
    rel_cyc = cyc;
    repeat (40) @(negedge clk);
    check("t6_no_start_on_stale_low", 32'(rx_if.busy_o), 32'(0));
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    xfer(8'h9A, 1'b1, 1'b0, 0);
    check_all("t6_after_reset");
    consume();

`ifdef UART_RX_PARITY_EN
    // 7: even parity
    parity_odd = 1'b0;
    xfer(8'h9A, 1'b1, 1'b1, 0);
    check_all("t7_parity_bad");
    consume();
    xfer(8'h9A, 1'b1, 1'b0, 0);
    check_all("t7_parity_good");
    consume();
`endif

    // Randomized frames, sometimes left unconsumed to provoke overrun
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rf = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 2) != 0) consume();
      if ($urandom_range(0, 3) == 0) flag_clear();
      xfer(rd, rs, rf, 0);
      check_all($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
